lt_seq_ctrl: RTL and testbench

- Control sequencer that drives the linear-transform datapath (accumulator, register file, folded MDS multiplier, round-constant generator) through a complete multi-round transform.
- Accepts a job (algorithm, direction, round count) and loads the plaintext/state P into ReF.
- Per round, handshakes a ReC word from the upstream round-key/S-box stage and issues the datapath control word for that round.
- Presents the final ReF to the downstream stage with a valid/ready handshake.

---
 rtl/lt_pkg.sv | 44 ++++
 rtl/lt_round_cnt.sv | 55 +++++
 rtl/lt_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_lt_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_pkg.sv
// Shared definitions for the linear-transform sequencer.
//   alg_e       : algorithm codes carried on cfg_alg / alg_mode
//   ref_sel_e   : register-file input select codes driven on mode_ref
//   accy_e      : accumulator y-source codes driven on ACC_src_y
//   lt_state_e  : sequencer FSM states
//   alg_reserved: true for algorithm codes with no defined datapath mapping
package lt_pkg;

    typedef enum logic [2:0] {
        ALG_MDS   = 3'd0,
        ALG_SPN24 = 3'd1,
        ALG_SPN32 = 3'd2
    } alg_e;

    typedef enum logic [2:0] {
        REF_SEL_D    = 3'b000,
        REF_SEL_RECL = 3'b001,
        REF_SEL_P    = 3'b010,
        REF_SEL_LT24 = 3'b011,
        REF_SEL_LT32 = 3'b100,
        REF_SEL_REC0 = 3'b101
    } ref_sel_e;

    typedef enum logic [1:0] {
        ACCY_ZERO = 2'b00,
        ACCY_REF  = 2'b01,
        ACCY_RDC  = 2'b10
    } accy_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_REC,
        ST_MDS_A,
        ST_MDS_B,
        ST_SPN,
        ST_OUT
    } lt_state_e;

    function automatic logic alg_reserved(input logic [2:0] alg);
        return alg > ALG_SPN32;
    endfunction

endpackage

// File: rtl/lt_round_cnt.sv
// Up/down round counter for the sequencer.
//   load   : capture rounds (saturated) and direction; cnt starts at 0
//            for encrypt or rounds-1 for decrypt
//   step   : advance one round (+1 encrypt, -1 decrypt)
//   cnt    : current round index
//   last   : cnt is the final round of the job
//   zero   : the latched round count is 0 (job has no rounds)
module lt_round_cnt #(
    parameter int RND_W   = 4,
    parameter int MAX_RND = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             dec,
    input  logic [RND_W-1:0] rounds,
    output logic [RND_W-1:0] cnt,
    output logic             last,
    output logic             zero
);

    logic [RND_W-1:0] rounds_sat;
    logic [RND_W-1:0] rounds_q;
    logic             dec_q;

    // Saturation only exists when MAX_RND is below the counter's range;
    // otherwise every representable count is legal as-is.
    generate
        if (MAX_RND < (1 << RND_W) - 1) begin : g_sat
            assign rounds_sat = (rounds > RND_W'(MAX_RND)) ? RND_W'(MAX_RND) : rounds;
        end else begin : g_nosat
            assign rounds_sat = rounds;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rounds_q <= '0;
            dec_q    <= 1'b0;
        end else if (load) begin
            rounds_q <= rounds_sat;
            dec_q    <= dec;
            // A zero-round decrypt must not wrap to all-ones.
            cnt      <= (dec && rounds_sat != '0) ? rounds_sat - RND_W'(1) : '0;
        end else if (step) begin
            cnt <= dec_q ? cnt - RND_W'(1) : cnt + RND_W'(1);
        end
    end

    assign last = dec_q ? (cnt == '0) : (cnt == rounds_q - RND_W'(1));
    assign zero = (rounds_q == '0);

endmodule

// File: rtl/lt_seq_ctrl.sv
// Control sequencer for the linear-transform datapath. Loads P into ReF,
// runs one datapath pass per round after taking a ReC word from upstream,
// then offers the final ReF downstream.
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both 1; rec_valid is ignored unless rec_ready=1, and
// res_valid stays high until res_ready is seen.
//   start/cfg_*          : job request, sampled only in IDLE
//   rec_valid/rec_ready  : upstream ReC word handshake
//   res_valid/res_ready  : downstream result handshake
//   busy, err            : status (err sticky until next accepted start)
//   alg_mode, mode_enc_dec, outer_round : latched job context
//   ACC_src_x/ACC_src_y/ReF_en/mode_ref/sel_op : datapath control word
module lt_seq_ctrl
    import lt_pkg::*;
#(
    parameter int RND_W   = 4,
    parameter int MAX_RND = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       cfg_alg,
    input  logic             cfg_dec,
    input  logic [RND_W-1:0] cfg_rounds,
    input  logic             rec_valid,
    output logic             rec_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             err,
    output logic [2:0]       alg_mode,
    output logic             mode_enc_dec,
    output logic [RND_W-1:0] outer_round,
    output logic             ACC_src_x,
    output logic [1:0]       ACC_src_y,
    output logic             ReF_en,
    output logic [2:0]       mode_ref,
    output logic             sel_op
);

    lt_state_e        state, state_next;
    logic             accept;
    logic             step;
    logic             last;
    logic             zero;
    logic [RND_W-1:0] cnt;

    assign accept = (state == ST_IDLE) && start && !alg_reserved(cfg_alg);

    lt_round_cnt #(
        .RND_W   (RND_W),
        .MAX_RND (MAX_RND)
    ) u_round_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (step),
        .dec    (cfg_dec),
        .rounds (cfg_rounds),
        .cnt    (cnt),
        .last   (last),
        .zero   (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            err          <= 1'b0;
            alg_mode     <= '0;
            mode_enc_dec <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                if (alg_reserved(cfg_alg)) begin
                    err <= 1'b1;
                end else begin
                    err          <= 1'b0;
                    alg_mode     <= cfg_alg;
                    mode_enc_dec <= cfg_dec;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        rec_ready  = 1'b0;
        res_valid  = 1'b0;
        ReF_en     = 1'b0;
        mode_ref   = REF_SEL_D;
        ACC_src_x  = 1'b0;
        ACC_src_y  = ACCY_ZERO;
        sel_op     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                ReF_en     = 1'b1;
                mode_ref   = REF_SEL_P;
                state_next = zero ? ST_OUT : ST_WAIT_REC;
            end
            ST_WAIT_REC: begin
                rec_ready = 1'b1;
                if (rec_valid) state_next = (alg_mode == ALG_MDS) ? ST_MDS_A : ST_SPN;
            end
            ST_MDS_A: begin
                state_next = ST_MDS_B;
            end
            ST_MDS_B, ST_SPN: begin
                ReF_en = 1'b1;
                if (state == ST_MDS_B) begin
                    sel_op    = 1'b1;
                    mode_ref  = REF_SEL_D;
                    ACC_src_y = ACCY_RDC;
                end else begin
                    mode_ref = (alg_mode == ALG_SPN24) ? REF_SEL_LT24 : REF_SEL_LT32;
                end
                if (last) begin
                    state_next = ST_OUT;
                end else begin
                    step       = 1'b1;
                    state_next = ST_WAIT_REC;
                end
            end
            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy        = (state != ST_IDLE);
    // The counter keeps its last value between jobs; present 0 while idle.
    assign outer_round = (state == ST_IDLE) ? '0 : cnt;

endmodule

// File: tb/tb_lt_seq_ctrl.sv
// Directed bench for lt_seq_ctrl: runs jobs with hand-computed latencies,
// round-index sequences and ReF write patterns, plus error, restart and
// mid-job reset cases.
module tb_lt_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] cfg_alg;
    logic       cfg_dec;
    logic [3:0] cfg_rounds;
    logic       rec_valid;
    logic       rec_ready;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       err;
    logic [2:0] alg_mode;
    logic       mode_enc_dec;
    logic [3:0] outer_round;
    logic       ACC_src_x;
    logic [1:0] ACC_src_y;
    logic       ReF_en;
    logic [2:0] mode_ref;
    logic       sel_op;

    lt_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_alg      (cfg_alg),
        .cfg_dec      (cfg_dec),
        .cfg_rounds   (cfg_rounds),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .err          (err),
        .alg_mode     (alg_mode),
        .mode_enc_dec (mode_enc_dec),
        .outer_round  (outer_round),
        .ACC_src_x    (ACC_src_x),
        .ACC_src_y    (ACC_src_y),
        .ReF_en       (ReF_en),
        .mode_ref     (mode_ref),
        .sel_op       (sel_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] round_q[$];
    logic [3:0] mode_q[$];
    logic [3:0] exp_q[$];
    int first_res, ref_cnt, sel_cnt, rdc_cnt, stall_bad, latch_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Compares the round-index queue (use_modes=0) or the ReF write-select
    // queue (use_modes=1) against exp_q.
    task automatic cmp_q(input string tag, input bit use_modes);
        int n;
        n = use_modes ? mode_q.size() : round_q.size();
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_%0d", tag, i), use_modes ? mode_q[i] : round_q[i], exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the edge that accepts start; first_res is the cycle index
    // of the first res_valid observed after it.
    task automatic run_job(input logic [2:0] alg, input logic dec, input logic [3:0] rounds,
                           input int stall_round, input int stall_len,
                           input int ready_low, input int restart_cyc);
        int cyc, stall_cnt, low_cnt;
        bit done, prev_lo;
        round_q.delete();
        mode_q.delete();
        first_res = -1; ref_cnt = 0; sel_cnt = 0; rdc_cnt = 0;
        stall_bad = 0; latch_bad = 0;
        stall_cnt = 0; low_cnt = 0; done = 0; prev_lo = 0;
        cfg_alg = alg; cfg_dec = dec; cfg_rounds = rounds;
        start = 1'b1; rec_valid = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        // Scramble the config inputs; the running job must not see this.
        cfg_alg = alg ^ 3'd3; cfg_dec = ~dec; cfg_rounds = rounds + 4'd5;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == restart_cyc) begin
                start = 1'b1; cfg_alg = 3'd2; cfg_dec = ~dec; cfg_rounds = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (alg_mode !== alg || mode_enc_dec !== dec || busy !== 1'b1) latch_bad++;
            if (rec_ready) begin
                if (round_q.size() == stall_round && stall_cnt < stall_len) begin
                    rec_valid = 1'b0;
                    stall_cnt++;
                    if (ReF_en || sel_op || mode_ref != 3'd0 || ACC_src_y != 2'd0 || ACC_src_x)
                        stall_bad++;
                end else begin
                    rec_valid = 1'b1;
                    round_q.push_back(outer_round);
                end
            end else begin
                rec_valid = 1'b1;
            end
            if (ReF_en) begin
                ref_cnt++;
                mode_q.push_back({1'b0, mode_ref});
            end
            if (sel_op) begin
                sel_cnt++;
                if (ACC_src_y == 2'b10 && ACC_src_x == 1'b0) rdc_cnt++;
            end
            if (prev_lo) check("res_hold", res_valid, 1);
            prev_lo = 0;
            if (res_valid) begin
                if (first_res < 0) first_res = cyc;
                if (low_cnt < ready_low) begin
                    res_ready = 1'b0;
                    low_cnt++;
                    prev_lo = 1;
                end else begin
                    res_ready = 1'b1;
                    done = 1;
                end
            end
            tick();
            cyc++;
        end
        if (!done) check("job_timeout", 0, 1);
        start = 1'b0; res_ready = 1'b1; rec_valid = 1'b1;
        check("idle_busy", busy, 0);
        check("idle_round", outer_round, 0);
        check("idle_res_valid", res_valid, 0);
        check("cfg_latched", latch_bad, 0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; cfg_alg = '0; cfg_dec = 1'b0; cfg_rounds = '0;
        rec_valid = 1'b0; res_ready = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_rec_ready", rec_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_ctrl", {ReF_en, mode_ref, ACC_src_x, ACC_src_y, sel_op}, 0);
        check("rst_ctx", {err, alg_mode, mode_enc_dec, outer_round}, 0);
        rst_n = 1'b1;
        tick();

        // MDS encrypt, 3 rounds: 2 + 3*3 = 11
        run_job(3'd0, 1'b0, 4'd3, -1, 0, 0, -1);
        check("mds_latency", first_res, 11);
        check("mds_ref_en", ref_cnt, 4);
        check("mds_sel_op", sel_cnt, 3);
        check("mds_acc_rdc", rdc_cnt, 3);
        exp_q = '{4'd0, 4'd1, 4'd2};            cmp_q("mds_round", 0);
        exp_q = '{4'd2, 4'd0, 4'd0, 4'd0};      cmp_q("mds_mode", 1);

        // SPN32 decrypt, 4 rounds: 2 + 2*4 = 10
        run_job(3'd2, 1'b1, 4'd4, -1, 0, 0, -1);
        check("spn32_latency", first_res, 10);
        check("spn32_sel_op", sel_cnt, 0);
        exp_q = '{4'd3, 4'd2, 4'd1, 4'd0};      cmp_q("spn32_round", 0);
        exp_q = '{4'd2, 4'd4, 4'd4, 4'd4, 4'd4}; cmp_q("spn32_mode", 1);

        // SPN24 encrypt, 2 rounds, 5-cycle ReC stall in round 1, 3-cycle result stall
        run_job(3'd1, 1'b0, 4'd2, 1, 5, 3, -1);
        check("stall_latency", first_res, 11);
        check("stall_ctrl_default", stall_bad, 0);
        exp_q = '{4'd0, 4'd1};                  cmp_q("stall_round", 0);
        exp_q = '{4'd2, 4'd3, 4'd3};            cmp_q("stall_mode", 1);

        // Zero rounds: LOAD then OUT
        run_job(3'd0, 1'b1, 4'd0, -1, 0, 0, -1);
        check("r0_latency", first_res, 2);
        check("r0_ref_en", ref_cnt, 1);
        check("r0_rec_hs", round_q.size(), 0);
        exp_q = '{4'd2};                        cmp_q("r0_mode", 1);

        // Reserved algorithm: err set, job not started
        cfg_alg = 3'd5; cfg_dec = 1'b0; cfg_rounds = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("rsv_err", err, 1);
        check("rsv_busy", busy, 0);
        tick();
        check("rsv_err_sticky", err, 1);
        check("rsv_busy_still", busy, 0);
        run_job(3'd1, 1'b1, 4'd1, -1, 0, 0, -1);
        check("err_cleared", err, 0);
        check("spn24d_latency", first_res, 4);
        exp_q = '{4'd0};                        cmp_q("spn24d_round", 0);

        // Second start while busy is ignored
        run_job(3'd0, 1'b0, 4'd2, -1, 0, 0, 3);
        check("restart_latency", first_res, 8);
        exp_q = '{4'd0, 4'd1};                  cmp_q("restart_round", 0);

        // Full 15-round SPN24 job: 2 + 2*15 = 32
        run_job(3'd1, 1'b0, 4'd15, -1, 0, 0, -1);
        check("r15_latency", first_res, 32);
        check("r15_rounds", round_q.size(), 15);
        if (round_q.size() == 15) check("r15_last_idx", round_q[14], 14);

        // Reset asserted during the second MDS_B of an MDS job
        cfg_alg = 3'd0; cfg_dec = 1'b0; cfg_rounds = 4'd3; start = 1'b1;
        rec_valid = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(sel_op && outer_round == 4'd1) && guard < 30) begin
            tick();
            guard++;
        end
        check("mdsb_reached", guard < 30, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ctrl", {ReF_en, mode_ref, ACC_src_x, ACC_src_y, sel_op}, 0);
        check("midrst_hs", {rec_ready, res_valid}, 0);
        check("midrst_ctx", {err, alg_mode, mode_enc_dec, outer_round}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job(3'd2, 1'b0, 4'd2, -1, 0, 0, -1);
        check("post_rst_latency", first_res, 6);
        exp_q = '{4'd2, 4'd4, 4'd4};            cmp_q("post_rst_mode", 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
